// File: rtl/idct_mul_sequencer.sv
// IDCT multiplier sequencer.
// Steps one block through LOAD, ROW, COL and FLUSH. It drives the phase code,
// the operand index and the clear/approximation controls of the multiplier
// wrapper, and it tracks when the wrapper's product P is valid.
module idct_mul_sequencer #(
  parameter int BLOCK_LEN = 64,
  parameter int PIPE_LAT  = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       abort,
  input  logic       apx_row,
  input  logic       apx_col,
  input  logic       op_valid,
  output logic       op_ready,
  output logic [2:0] state,
  output logic [8:0] count0,
  output logic       rstP,
  output logic       racc,
  output logic       rapx,
  output logic       p_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_ROW   = 3'b010,
    S_COL   = 3'b011,
    S_FLUSH = 3'b100
  } phase_e;

  localparam logic [8:0] LAST_IDX   = 9'(BLOCK_LEN - 1);
  localparam logic [8:0] FLUSH_LAST = 9'(PIPE_LAT);

  phase_e              state_q, state_d;
  logic [8:0]          count_q, count_d;
  logic                mode_row_q, mode_row_d;
  logic                mode_col_q, mode_col_d;
  logic                ready_q, ready_d;
  logic                rstp_q, rstp_d;
  logic                racc_q, racc_d;
  logic                rapx_q, rapx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d, pipe_shift;
  logic                accept;
  logic                abort_busy;
  logic                prod_accept;

  // An abort only matters while a block is in flight; in IDLE it is ignored.
  assign abort_busy  = abort & busy_q;
  // Ready is dropped combinationally by abort so an aborted cycle never
  // completes a handshake upstream (abort beats a coincident accept).
  assign op_ready    = ready_q & ~abort;
  assign accept      = op_valid & op_ready;
  // Only ROW and COL accepts feed real multiplications into the wrapper.
  assign prod_accept = accept & ((state_q == S_ROW) | (state_q == S_COL));

  // Phase, operand index and latched approximation modes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mode_row_q <= 1'b0;
      mode_col_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_row_q <= mode_row_d;
      mode_col_q <= mode_col_d;
    end
  end

  // Next phase: advance on the phase-final accept; FLUSH is a fixed countdown.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_row_d = mode_row_q;
    mode_col_d = mode_col_q;
    if (abort_busy) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = '0;
          if (start && !abort) begin
            state_d    = S_LOAD;
            mode_row_d = apx_row;
            mode_col_d = apx_col;
          end
        end
        S_LOAD, S_ROW, S_COL: begin
          if (accept) begin
            if (count_q == LAST_IDX) begin
              count_d = '0;
              case (state_q)
                S_LOAD:  state_d = S_ROW;
                S_ROW:   state_d = S_COL;
                default: state_d = S_FLUSH;
              endcase
            end else begin
              count_d = count_q + 9'd1;
            end
          end
        end
        S_FLUSH: begin
          if (count_q == FLUSH_LAST) begin
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 9'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Next values of the registered controls, derived from the upcoming phase.
  always_comb begin
    ready_d = (state_d == S_LOAD) | (state_d == S_ROW) | (state_d == S_COL);
    busy_d  = (state_d != S_IDLE);
    racc_d  = (state_d == S_IDLE);
    case (state_d)
      S_LOAD, S_ROW: rapx_d = mode_row_d;
      S_COL:         rapx_d = mode_col_d;
      default:       rapx_d = 1'b0;
    endcase
    rstp_d = abort_busy | ((state_q == S_IDLE) & (state_d == S_LOAD));
    done_d = (state_q == S_FLUSH) & (state_d == S_IDLE) & ~abort;
    pipe_d = abort_busy ? '0 : pipe_shift;
  end

  // Product-valid delay line: one stage per cycle of multiplier latency.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_shift[gi] = prod_accept;
      end else begin : g_tail
        assign pipe_shift[gi] = pipe_q[gi-1];
      end
    end
  endgenerate

  // Output registers and the valid delay line.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ready_q <= 1'b0;
      rstp_q  <= 1'b0;
      racc_q  <= 1'b1;
      rapx_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= '0;
    end else begin
      ready_q <= ready_d;
      rstp_q  <= rstp_d;
      racc_q  <= racc_d;
      rapx_q  <= rapx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pipe_q  <= pipe_d;
    end
  end

  assign state   = state_q;
  assign count0  = count_q;
  assign rstP    = rstp_q;
  assign racc    = racc_q;
  assign rapx    = rapx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign p_valid = pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_idct_mul_sequencer.sv
// Bench for idct_mul_sequencer: a phase-level model for the default
// configuration checked every cycle, plus literal expectations for block
// latency, product counts and a small PIPE_LAT=3 / BLOCK_LEN=8 instance.
module tb_idct_mul_sequencer;

  localparam int BL1 = 64;
  localparam int PL1 = 1;

  logic       clk;
  logic       rstN;
  logic       start, abort, apx_row, apx_col, op_valid;
  logic       op_ready, rstP, racc, rapx, p_valid, busy, done;
  logic [2:0] state;
  logic [8:0] count0;

  logic       start2, abort2, apx_row2, apx_col2, op_valid2;
  logic       op_ready2, rstP2, racc2, rapx2, p_valid2, busy2, done2;
  logic [2:0] state2;
  logic [8:0] count02;

  idct_mul_sequencer #(.BLOCK_LEN(BL1), .PIPE_LAT(PL1)) u_dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort),
    .apx_row(apx_row), .apx_col(apx_col), .op_valid(op_valid),
    .op_ready(op_ready), .state(state), .count0(count0), .rstP(rstP),
    .racc(racc), .rapx(rapx), .p_valid(p_valid), .busy(busy), .done(done)
  );

  idct_mul_sequencer #(.BLOCK_LEN(8), .PIPE_LAT(3)) u_dut2 (
    .clk(clk), .rstN(rstN), .start(start2), .abort(abort2),
    .apx_row(apx_row2), .apx_col(apx_col2), .op_valid(op_valid2),
    .op_ready(op_ready2), .state(state2), .count0(count02), .rstP(rstP2),
    .racc(racc2), .rapx(rapx2), .p_valid(p_valid2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tb_cyc = 0;
  initial forever begin
    @(posedge clk);
    tb_cyc = tb_cyc + 1;
  end

  // Driver-owned scenario bookkeeping.
  int start_cyc  = -100;
  int abort_cyc  = -100;
  int start2_cyc = -100;
  bit chk_lat    = 1'b0;
  bit chk_pv     = 1'b0;
  int timeouts   = 0;

  // Compare-process-owned counters.
  int errors  = 0;
  int checks  = 0;
  int to_seen = 0;
  int pv_blk  = 0;
  int pv2     = 0;
  int f2_len  = 0;
  int f2_pos  = 0;

  // ---------------- behavioural model (phase/index + due-time queue) -------
  int m_phase = 0;
  int m_idx   = 0;
  int m_cyc   = 0;
  bit m_mr    = 1'b0;
  bit m_mc    = 1'b0;
  bit m_rstp  = 1'b0;
  bit m_done  = 1'b0;
  int pvq[$];

  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        m_phase = 0; m_idx = 0; m_mr = 0; m_mc = 0; m_rstp = 0; m_done = 0;
        pvq.delete();
      end else begin
        acc = op_valid && (m_phase >= 1 && m_phase <= 3) && !abort;
        while (pvq.size() > 0 && pvq[0] <= m_cyc) void'(pvq.pop_front());
        m_rstp = 0;
        m_done = 0;
        if (m_phase != 0 && abort) begin
          m_phase = 0; m_idx = 0; m_rstp = 1;
          pvq.delete();
        end else begin
          case (m_phase)
            0: if (start && !abort) begin
                 m_phase = 1; m_idx = 0; m_mr = apx_row; m_mc = apx_col; m_rstp = 1;
               end
            1, 2, 3: if (acc) begin
                 if (m_phase >= 2) pvq.push_back(m_cyc + PL1);
                 if (m_idx == BL1 - 1) begin m_phase = m_phase + 1; m_idx = 0; end
                 else m_idx = m_idx + 1;
               end
            default: if (m_idx == PL1) begin m_phase = 0; m_idx = 0; m_done = 1; end
                     else m_idx = m_idx + 1;
          endcase
        end
        m_cyc = m_cyc + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  // ---------------- compare process ----------------------------------------
  initial forever begin
    @(negedge clk);
    if (timeouts != to_seen) begin
      chk("wait_timeout", 16'(timeouts), 16'(to_seen));
      to_seen = timeouts;
    end
    if (!rstN) begin
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_count0", 16'(count0), 16'd0);
      chk("rst_racc", 16'(racc), 16'd1);
      chk("rst_rapx", 16'(rapx), 16'd0);
      chk("rst_rstP", 16'(rstP), 16'd0);
      chk("rst_op_ready", 16'(op_ready), 16'd0);
      chk("rst_p_valid", 16'(p_valid), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_state2", 16'(state2), 16'd0);
      chk("rst_racc2", 16'(racc2), 16'd1);
    end else begin
      chk("state", 16'(state), 16'(m_phase));
      chk("count0", 16'(count0), 16'(m_idx));
      chk("racc", 16'(racc), 16'(m_phase == 0));
      chk("rapx", 16'(rapx), 16'((m_phase == 1 || m_phase == 2) ? m_mr : (m_phase == 3) ? m_mc : 1'b0));
      chk("rstP", 16'(rstP), 16'(m_rstp));
      chk("op_ready", 16'(op_ready), 16'((m_phase >= 1 && m_phase <= 3) && !abort));
      chk("p_valid", 16'(p_valid), 16'(pvq.size() > 0 && pvq[0] == m_cyc));
      chk("busy", 16'(busy), 16'(m_phase != 0));
      chk("done", 16'(done), 16'(m_done));

      if (tb_cyc == start_cyc + 1) pv_blk = 0;
      if (p_valid === 1'b1) pv_blk = pv_blk + 1;
      if (done === 1'b1) begin
        if (chk_lat) chk("done_latency", 16'(tb_cyc - start_cyc), 16'd195);
        if (chk_pv)  chk("p_valid_count", 16'(pv_blk), 16'd128);
      end
      if (tb_cyc == abort_cyc + 1) begin
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_rstP", 16'(rstP), 16'd1);
        chk("abort_count0", 16'(count0), 16'd0);
      end

      if (state2 == 3'd4) f2_len = f2_len + 1;
      if (p_valid2 === 1'b1) begin
        pv2 = pv2 + 1;
        if (state2 == 3'd4) f2_pos = f2_len;
      end
      if (done2 === 1'b1) begin
        chk("flush2_len", 16'(f2_len), 16'd4);
        chk("flush2_last_pv_pos", 16'(f2_pos), 16'd3);
        chk("p_valid2_count", 16'(pv2), 16'd16);
        chk("done2_latency", 16'(tb_cyc - start2_cyc), 16'd29);
      end
    end
  end

  // ---------------- driver --------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_at(input logic [2:0] st, input int cnt, input int budget);
    int n = 0;
    while (!(state == st && count0 == 9'(cnt)) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeouts = timeouts + 1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeouts = timeouts + 1;
  endtask

  task automatic run_block(input bit row_m, input bit col_m);
    op_valid = 1'b1; apx_row = row_m; apx_col = col_m;
    chk_lat = 1'b1; chk_pv = 1'b1;
    start = 1'b1; start_cyc = tb_cyc;
    step();
    start = 1'b0; apx_row = ~row_m; apx_col = ~col_m;
    wait_done(300);
    $display("block row_apx=%0b col_apx=%0b started at cycle %0d", row_m, col_m, start_cyc);
  endtask

  initial begin
    rstN = 1'b0; start = 0; abort = 0; apx_row = 0; apx_col = 0; op_valid = 0;
    start2 = 0; abort2 = 0; apx_row2 = 0; apx_col2 = 0; op_valid2 = 0;
    repeat (3) step();
    rstN = 1'b1;
    step(); step();

    // abort alone, then start with abort, in IDLE
    abort = 1'b1; step();
    start = 1'b1; step();
    start = 1'b0; abort = 1'b0; step();
    $display("idle abort / start+abort applied");

    // full block, modes changed after start to prove latching
    run_block(1'b1, 1'b0);
    step(); step();

    // op_valid toggling, with an ignored start pulse mid-block
    apx_row = 0; apx_col = 1; op_valid = 1;
    chk_lat = 0; chk_pv = 1;
    start = 1; start_cyc = tb_cyc; step(); start = 0;
    for (int n = 0; n < 600 && done !== 1'b1; n++) begin
      op_valid = ~op_valid;
      start = (n == 100);
      step();
    end
    if (done !== 1'b1) timeouts = timeouts + 1;
    start = 0;
    $display("toggling op_valid block started at cycle %0d", start_cyc);
    step(); step();

    // abort at ROW count0=30
    chk_lat = 0; chk_pv = 0; op_valid = 1; apx_row = 1; apx_col = 1;
    start = 1; start_cyc = tb_cyc; step(); start = 0;
    wait_at(3'd2, 30, 200);
    abort = 1; abort_cyc = tb_cyc; step(); abort = 0;
    repeat (6) step();
    $display("abort at ROW index 30, cycle %0d", abort_cyc);

    // abort coincident with final COL accept
    start = 1; start_cyc = tb_cyc; step(); start = 0;
    wait_at(3'd3, 63, 300);
    abort = 1; abort_cyc = tb_cyc; step(); abort = 0;
    repeat (6) step();
    $display("abort at COL index 63, cycle %0d", abort_cyc);

    // asynchronous reset in COL at count0=10, then a fresh block
    start = 1; start_cyc = tb_cyc; step(); start = 0;
    wait_at(3'd3, 10, 300);
    rstN = 1'b0; step(); step();
    rstN = 1'b1; step();
    $display("reset pulse in COL index 10");
    run_block(1'b0, 1'b1);
    step(); step();

    // small instance: BLOCK_LEN=8, PIPE_LAT=3
    op_valid2 = 1; start2 = 1; start2_cyc = tb_cyc; step(); start2 = 0;
    for (int n = 0; n < 60 && done2 !== 1'b1; n++) step();
    if (done2 !== 1'b1) timeouts = timeouts + 1;
    $display("small instance block started at cycle %0d", start2_cyc);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idct_mul_sequencer.md
IDCT_MUL_SEQUENCER -- requirements
Module: idct_mul_sequencer

Interface
REQ-001 Parameter: BLOCK_LEN, default 64, operands accepted per phase (2..256).
REQ-002 Parameter: PIPE_LAT, default 1, cycles from operand acceptance to the multiplier wrapper's P being valid (1..4).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rstN  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  begin one block (LOAD, ROW, COL, FLUSH).
REQ-006 Port: abort  in  1  synchronous abandon of the current block.
REQ-007 Port: apx_row  in  1  approximate mode for ROW phase, sampled at start.
REQ-008 Port: apx_col  in  1  approximate mode for COL phase, sampled at start.
REQ-009 Port: op_valid  in  1  upstream operand pair available.
REQ-010 Port: op_ready  out  1  sequencer accepts operand this cycle.
REQ-011 Port: state  out  3  phase code to wrapper: IDLE=000, LOAD=001, ROW=010, COL=011, FLUSH=100.
REQ-012 Port: count0  out  9  accepted-operand index within current phase.
REQ-013 Port: rstP  out  1  product-register clear pulse to wrapper.
REQ-014 Port: racc  out  1  accurate-bit operand clear, active high.
REQ-015 Port: rapx  out  1  approximate-bit operand clear, active high.
REQ-016 Port: p_valid  out  1  wrapper P holds a valid ROW/COL product.
REQ-017 Port: busy  out  1  high whenever state != IDLE.
REQ-018 Port: done  out  1  one-cycle block-complete pulse.

Function
REQ-019 All outputs registered; op_ready = 1 exactly when state is LOAD, ROW or COL and abort = 0.
REQ-020 Accept = op_valid & op_ready; count0 increments by 1 per accept and holds otherwise.
REQ-021 IDLE: start = 1 -> LOAD next cycle, count0 = 0, apx_row/apx_col latched; start ignored when busy = 1.
REQ-022 LOAD: accept with count0 = BLOCK_LEN-1 -> ROW, count0 = 0.
REQ-023 ROW: accept with count0 = BLOCK_LEN-1 -> COL, count0 = 0.
REQ-024 COL: accept with count0 = BLOCK_LEN-1 -> FLUSH, count0 = 0.
REQ-025 FLUSH: lasts exactly PIPE_LAT+1 cycles (count0 counts 0..PIPE_LAT), then IDLE with done = 1 in the first IDLE cycle.
REQ-026 count0 never exceeds BLOCK_LEN-1; count0 = 0 in IDLE.
REQ-027 rstP = 1 for exactly the first cycle of LOAD and the first cycle after any abort; 0 otherwise.
REQ-028 racc = 1 in IDLE, 0 in all other states.
REQ-029 rapx = latched apx_row in LOAD and ROW, latched apx_col in COL, 0 in IDLE and FLUSH.
REQ-030 p_valid = 1 exactly PIPE_LAT cycles after each accept made in ROW or COL; LOAD accepts never produce p_valid.
REQ-031 p_valid tracking uses a PIPE_LAT-deep shift register, so products from the last COL accepts drain during FLUSH.
REQ-032 abort = 1 in any non-IDLE state -> IDLE next cycle, count0 = 0, p_valid pipeline cleared, done = 0, rstP = 1 for that cycle.
REQ-033 abort in the same cycle as a phase-final accept: abort wins; the accept is discarded.
REQ-034 abort in IDLE has no effect; start and abort together in IDLE: abort wins, stay IDLE.
REQ-035 The block raises no error and keeps no state for op_valid pulses when op_ready = 0.

Reset
REQ-036 rstN = 0 forces asynchronously: state = 000, count0 = 0, racc = 1, rapx = 0, rstP = 0, op_ready = 0, p_valid = 0, busy = 0, done = 0, latched modes = 0, p_valid pipeline = 0.
REQ-037 Reset mid-block discards all progress; after rstN rises, the first rising edge with start = 1 begins a fresh LOAD.

Verification
REQ-038 Defaults, op_valid held 1, start pulse with apx_row = 1, apx_col = 0 -> LOAD 64 cycles, ROW 64 cycles (rapx = 1), COL 64 cycles (rapx = 0), FLUSH 2 cycles, done at cycle 195 after start, 128 p_valid pulses.
REQ-039 op_valid toggling 1,0,1,0 in ROW -> count0 advances every other cycle; p_valid follows each accept by exactly 1 cycle.
REQ-040 abort at ROW count0 = 30 -> next cycle state = 000, rstP = 1, count0 = 0, no done, no further p_valid.
REQ-041 abort coincident with COL count0 = 63 accept -> IDLE, done never asserted, FLUSH never entered.
REQ-042 rstN pulsed low in COL at count0 = 10 -> immediate reset values of REQ-036; subsequent start runs a full block correctly.
REQ-043 PIPE_LAT = 3, BLOCK_LEN = 8 -> FLUSH lasts 4 cycles; the last p_valid appears in the third FLUSH cycle.
